// File: rtl/inst_fetch.sv
// Instruction fetch unit: samples the PC on a fetch strobe, runs a single
// read transaction against instruction memory and returns the word and PC+4.
// Optional wait timeout is enabled by defining INST_FETCH_TIMEOUT_EN.
module inst_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] pc_reg,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic        misalign,
    output logic        fetch_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        err_q, err_d;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    logic [15:0] cnt_q, cnt_d, cnt_inc;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pc_next_d  = pc_next_q;
        inst_d     = inst_q;
        valid_d    = 1'b0;
        misalign_d = 1'b0;
        err_d      = 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        cnt_inc    = cnt_q + 16'd1;
`endif
        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    if (pc_reg[1:0] == 2'b00) begin
                        state_d   = S_WAIT;
                        addr_d    = pc_reg;
                        pc_next_d = pc_reg + 32'd4;
`ifdef INST_FETCH_TIMEOUT_EN
                        cnt_d     = 16'd0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // An ack always beats a timeout landing in the same cycle.
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef INST_FETCH_TIMEOUT_EN
                else if (cnt_inc == TIMEOUT_W) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'd0;
            pc_next_q  <= 32'd0;
            inst_q     <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
            cnt_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_next_q  <= pc_next_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
`ifdef INST_FETCH_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign imem_req   = (state_q == S_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign imem_addr  = addr_q;
    assign pc_next    = pc_next_q;
    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign misalign   = misalign_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// fetch transactions checked against a transaction-level expectation model.
module tb_inst_fetch;

`ifdef INST_FETCH_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_next;
    logic        busy;
    logic        misalign;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    // Architectural state the design should be exposing between transactions.
    logic [31:0] modelInst;
    logic [31:0] modelPcNext;

    inst_fetch #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_reg(pc_reg),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .pc_next(pc_next), .busy(busy), .misalign(misalign), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; outputs are examined 1 time unit afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] pc, input logic ack, input logic [31:0] rd);
        fetch_en   = en;
        pc_reg     = pc;
        imem_ack   = ack;
        imem_rdata = rd;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".req"}, 32'(imem_req), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
        checkOutput({tag, ".inst"}, inst, modelInst);
        checkOutput({tag, ".pcnext"}, pc_next, modelPcNext);
        checkOutput({tag, ".pulses"}, {29'd0, inst_valid, misalign, fetch_err}, 32'd0);
    endtask

    task automatic checkWaiting(input string tag, input logic [31:0] pc);
        checkOutput({tag, ".req"}, 32'(imem_req), 32'd1);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
        checkOutput({tag, ".addr"}, imem_addr, pc);
        checkOutput({tag, ".pulses"}, {29'd0, inst_valid, misalign, fetch_err}, 32'd0);
    endtask

    // One fetch: ackDelay cycles of request without ack, then ack.
    // disturb adds a second fetch_en during WAIT and a spurious ack once idle.
    task automatic fetchTxn(input string tag, input logic [31:0] pc, input int ackDelay,
                            input logic [31:0] rd, input logic disturb);
        applyStimulus(1'b1, pc, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, pc, 1'b0, 32'h0);
        if (pc[1:0] != 2'b00) begin
            checkOutput({tag, ".misalign"}, 32'(misalign), 32'd1);
            checkOutput({tag, ".mreq"}, 32'(imem_req), 32'd0);
            checkOutput({tag, ".mbusy"}, 32'(busy), 32'd0);
            checkOutput({tag, ".minst"}, inst, modelInst);
            checkOutput({tag, ".mpcnext"}, pc_next, modelPcNext);
            tick();
            checkIdle({tag, ".after"});
            return;
        end
        modelPcNext = pc + 32'd4;
        for (int k = 0; k < ackDelay; k++) begin
            checkWaiting({tag, ".wait"}, pc);
            if (disturb && k == 0)
                applyStimulus(1'b1, pc ^ 32'h0000_1000, 1'b0, 32'h0);
            tick();
            applyStimulus(1'b0, pc, 1'b0, 32'h0);
        end
        checkWaiting({tag, ".ackcyc"}, pc);
        applyStimulus(disturb, pc ^ 32'h0000_2000, 1'b1, rd);
        tick();
        applyStimulus(1'b0, pc, 1'b0, 32'h0);
        modelInst = rd;
        checkOutput({tag, ".valid"}, 32'(inst_valid), 32'd1);
        checkOutput({tag, ".inst"}, inst, rd);
        checkOutput({tag, ".pcnext"}, pc_next, modelPcNext);
        checkOutput({tag, ".reqdrop"}, 32'(imem_req), 32'd0);
        checkOutput({tag, ".others"}, {30'd0, misalign, fetch_err}, 32'd0);
        if (disturb)
            applyStimulus(1'b0, pc, 1'b1, ~rd);
        tick();
        applyStimulus(1'b0, pc, 1'b0, 32'h0);
        checkIdle({tag, ".post"});
    endtask

    initial begin
        logic [31:0] rpc;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        modelInst   = 32'd0;
        modelPcNext = 32'd0;
        checkIdle("reset");
        checkOutput("reset.addr", imem_addr, 32'd0);

        fetchTxn("basic", 32'h0000_0100, 2, 32'h1234_5678, 1'b0);
        fetchTxn("wrap", 32'hFFFF_FFFC, 0, 32'hCAFE_F00D, 1'b0);
        fetchTxn("misal", 32'h0000_0102, 0, 32'h0, 1'b0);
        fetchTxn("busyign", 32'h0000_0200, 2, 32'hA5A5_5A5A, 1'b1);

        // Reset while waiting abandons the request; the late ack must be ignored.
        applyStimulus(1'b1, 32'h0000_0300, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkWaiting("rstwait.pre", 32'h0000_0300);
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0000_0400, 1'b1, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hBEEF_DEAD);
        modelInst   = 32'd0;
        modelPcNext = 32'd0;
        checkIdle("rstwait.edge");
        checkOutput("rstwait.addr", imem_addr, 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        checkIdle("rstwait.lateack");

`ifdef INST_FETCH_TIMEOUT_EN
        applyStimulus(1'b1, 32'h0000_0500, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        modelPcNext = 32'h0000_0504;
        for (int k = 0; k < int'(TMO); k++) begin
            checkWaiting("tmo.wait", 32'h0000_0500);
            tick();
        end
        checkOutput("tmo.err", 32'(fetch_err), 32'd1);
        checkOutput("tmo.req", 32'(imem_req), 32'd0);
        checkOutput("tmo.busy", 32'(busy), 32'd0);
        checkOutput("tmo.inst", inst, modelInst);
        tick();
        checkIdle("tmo.after");
`else
        applyStimulus(1'b1, 32'h0000_0500, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 110; k++) tick();
        checkWaiting("noTmo.hold", 32'h0000_0500);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0BAD_CAFE);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
        modelInst   = 32'h0BAD_CAFE;
        modelPcNext = 32'h0000_0504;
        checkOutput("noTmo.valid", 32'(inst_valid), 32'd1);
        checkOutput("noTmo.inst", inst, modelInst);
        tick();
        checkIdle("noTmo.after");
`endif

        for (int n = 0; n < 40; n++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            fetchTxn("rand", rpc, int'($urandom_range(0, (TMO > 3) ? 3 : TMO - 1)),
                     $urandom, 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
